// File: rtl/noc_pkg.sv
// Shared NoC definitions: destination address layout and the ingress drain states.
package noc_pkg;

    localparam int DEST_W       = 6;
    localparam int GROUP_ID_LSB = 3;
    localparam int GROUP_ID_W   = 3;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ISSUE        = 2'd1,
        WAIT_ACCEPT  = 2'd2,
        WAIT_RELEASE = 2'd3
    } drain_state_t;

    // Upper address bits select the router group a destination belongs to.
    function automatic logic [GROUP_ID_W-1:0] dest_group(input logic [DEST_W-1:0] dest);
        return dest[GROUP_ID_LSB +: GROUP_ID_W];
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock circular FIFO; pointers carry an extra wrap bit to tell full from empty.
module noc_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign count   = cnt;
    assign rd_data = mem[rptr[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is deliberately left out of reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/leaf_gpu_ingress_queue.sv
// GPU ingress queue for the leaf router: buffers flits and issues them one at a time,
// treating crossbar_busy as the accept and reissuing the head after a timeout.
module leaf_gpu_ingress_queue
    import noc_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DWIDTH-1:0]             gpu_in_data,
    input  logic                          gpu_in_valid,
    input  logic [DEST_W-1:0]             gpu_in_dest,
    output logic                          gpu_in_ready,
    input  logic                          arb_enable,
    input  logic                          crossbar_busy,
    output logic [DWIDTH-1:0]             rtr_data,
    output logic                          rtr_valid,
    output logic [DEST_W-1:0]             rtr_dest_addr,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    retry_count
);

    localparam int EW  = DEST_W + DWIDTH;
    localparam int WCW = $clog2(TIMEOUT + 1);

    drain_state_t   state;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_next;
    logic [EW-1:0]  head;
    logic [EW-1:0]  tail;
    logic           push;
    logic           pop;

    assign tail         = {gpu_in_dest, gpu_in_data};
    assign gpu_in_ready = !fifo_full;
    assign push         = gpu_in_valid && gpu_in_ready;
    // The head stays queued until the router shows it has taken the flit.
    assign pop          = (state == WAIT_ACCEPT) && crossbar_busy;
    assign wait_next    = wait_cnt + 1'b1;

    noc_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (tail),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            rtr_valid     <= 1'b0;
            rtr_data      <= '0;
            rtr_dest_addr <= '0;
            retry_count   <= '0;
        end else begin
            rtr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty && arb_enable) begin
                        state         <= ISSUE;
                        rtr_valid     <= 1'b1;
                        rtr_data      <= head[DWIDTH-1:0];
                        rtr_dest_addr <= head[EW-1:DWIDTH];
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: begin
                    // An accept seen on the timeout cycle still counts; no retry then.
                    if (crossbar_busy) begin
                        state <= WAIT_RELEASE;
                    end else begin
                        wait_cnt <= wait_next;
                        if (wait_next == WCW'(TIMEOUT)) begin
                            state <= IDLE;
                            if (retry_count != 8'hFF) begin
                                retry_count <= retry_count + 1'b1;
                            end
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (!crossbar_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_gpu_ingress_queue.sv
// Randomised bench for leaf_gpu_ingress_queue against a queue-based model of the issue/accept protocol.
module tb_leaf_gpu_ingress_queue;

    localparam int DWIDTH      = 16;
    localparam int FIFO_DEPTH  = 8;
    localparam int TIMEOUT     = 15;
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int ISSUE_BOUND = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [DWIDTH-1:0] gpu_in_data;
    logic              gpu_in_valid;
    logic [5:0]        gpu_in_dest;
    logic              gpu_in_ready;
    logic              arb_enable;
    logic              crossbar_busy;
    logic [DWIDTH-1:0] rtr_data;
    logic              rtr_valid;
    logic [5:0]        rtr_dest_addr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [7:0]        retry_count;

    logic [21:0] model_q[$];
    int assert_count = 0;
    int fail_count   = 0;
    int pulse_count  = 0;

    leaf_gpu_ingress_queue #(
        .DWIDTH     (DWIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gpu_in_data   (gpu_in_data),
        .gpu_in_valid  (gpu_in_valid),
        .gpu_in_dest   (gpu_in_dest),
        .gpu_in_ready  (gpu_in_ready),
        .arb_enable    (arb_enable),
        .crossbar_busy (crossbar_busy),
        .rtr_data      (rtr_data),
        .rtr_valid     (rtr_valid),
        .rtr_dest_addr (rtr_dest_addr),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_count    (fifo_count),
        .retry_count   (retry_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rtr_valid === 1'b1) pulse_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(rtr_valid), 32'd0);
        checkOutput("rst_empty", 32'(fifo_empty), 32'd1);
        checkOutput("rst_full",  32'(fifo_full), 32'd0);
        checkOutput("rst_ready", 32'(gpu_in_ready), 32'd1);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_retry", 32'(retry_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
    endtask

    // Offers one flit at the next edge; the model takes it only if there is room.
    task automatic applyStimulus(input logic [15:0] d, input logic [5:0] a);
        @(negedge clk);
        checkOutput("in_ready", 32'(gpu_in_ready), 32'(model_q.size() < FIFO_DEPTH));
        gpu_in_valid = 1'b1;
        gpu_in_data  = d;
        gpu_in_dest  = a;
        @(posedge clk);
        if (model_q.size() < FIFO_DEPTH) model_q.push_back({a, d});
    endtask

    task automatic idleInputs();
        @(negedge clk);
        gpu_in_valid = 1'b0;
    endtask

    task automatic waitIssue(output int n, output bit ok);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rtr_valid !== 1'b1 && n < ISSUE_BOUND);
        ok = (rtr_valid === 1'b1);
        if (!ok) checkOutput("issue_wait", 32'd0, 32'd1);
    endtask

    task automatic drainOne(input bit drop_arb, output int n);
        bit ok;
        logic [21:0] exp;
        waitIssue(n, ok);
        if (ok) begin
            exp = (model_q.size() > 0) ? model_q[0] : 22'h0;
            checkOutput("rtr_data", 32'(rtr_data), 32'(exp[15:0]));
            checkOutput("rtr_dest", 32'(rtr_dest_addr), 32'(exp[21:16]));
            @(negedge clk);
            checkOutput("valid_pulse", 32'(rtr_valid), 32'd0);
            crossbar_busy = 1'b1;
            if (drop_arb) arb_enable = 1'b0;
            @(negedge clk);
            crossbar_busy = 1'b0;
            if (model_q.size() > 0) void'(model_q.pop_front());
            checkOutput("count_after_pop", 32'(fifo_count), 32'(model_q.size()));
        end
    endtask

    initial begin
        int n;
        bit ok;
        int p0;
        reset = 1'b1; gpu_in_valid = 1'b0; gpu_in_data = '0; gpu_in_dest = '0;
        arb_enable = 1'b0; crossbar_busy = 1'b0;

        // Single flit: two-cycle latency, one-cycle pulse, queue empties after accept.
        doReset();
        arb_enable = 1'b1;
        applyStimulus(16'hA5A5, 6'h13);
        idleInputs();
        checkOutput("latency_pre", 32'(rtr_valid), 32'd0);
        checkOutput("count_one", 32'(fifo_count), 32'd1);
        drainOne(1'b0, n);
        checkOutput("latency", 32'(n), 32'd1);
        checkOutput("empty_after", 32'(fifo_empty), 32'd1);
        checkOutput("retry_zero", 32'(retry_count), 32'd0);

        // Fill to capacity; the ninth flit must be refused while held.
        doReset();
        arb_enable = 1'b1;
        for (int i = 0; i < 9; i++) applyStimulus(16'($urandom), 6'($urandom));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("full_flag", 32'(fifo_full), 32'd1);
            checkOutput("full_count", 32'(fifo_count), 32'(FIFO_DEPTH));
            checkOutput("full_ready", 32'(gpu_in_ready), 32'd0);
        end
        gpu_in_valid = 1'b0;

        // Never accepted: periodic reissue of the same head, then saturation.
        doReset();
        arb_enable = 1'b1;
        applyStimulus(16'($urandom), 6'($urandom));
        idleInputs();
        waitIssue(n, ok);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                waitIssue(n, ok);
                checkOutput("retry_spacing", 32'(n), 32'(TIMEOUT + 2));
            end
            checkOutput("retry_data", 32'(rtr_data), 32'(model_q[0][15:0]));
            checkOutput("retry_dest", 32'(rtr_dest_addr), 32'(model_q[0][21:16]));
            checkOutput("retry_count", 32'(retry_count), 32'(k));
            checkOutput("head_kept", 32'(fifo_count), 32'd1);
        end
        repeat (260 * (TIMEOUT + 2)) @(negedge clk);
        checkOutput("retry_saturate", 32'(retry_count), 32'd255);

        // Twenty flits in three batches so both pointers wrap.
        doReset();
        for (int b = 0; b < 3; b++) begin
            int batch;
            batch = (b == 0) ? 5 : (b == 1) ? 8 : 7;
            arb_enable = 1'b0;
            for (int i = 0; i < batch; i++) applyStimulus(16'($urandom), 6'($urandom));
            idleInputs();
            checkOutput("batch_count", 32'(fifo_count), 32'(batch));
            checkOutput("batch_full", 32'(fifo_full), 32'(batch == FIFO_DEPTH));
            arb_enable = 1'b1;
            for (int i = 0; i < batch; i++) drainOne(1'b0, n);
        end
        checkOutput("wrap_count_end", 32'(fifo_count), 32'd0);
        checkOutput("wrap_empty_end", 32'(fifo_empty), 32'd1);

        // arb_enable gates only new issues.
        doReset();
        arb_enable = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), 6'($urandom));
        idleInputs();
        p0 = pulse_count;
        repeat (10) @(negedge clk);
        checkOutput("arb_block", 32'(pulse_count - p0), 32'd0);
        arb_enable = 1'b1;
        drainOne(1'b1, n);
        checkOutput("arb_latency", 32'(n), 32'd1);
        p0 = pulse_count;
        repeat (10) @(negedge clk);
        checkOutput("arb_hold", 32'(pulse_count - p0), 32'd0);
        checkOutput("arb_count", 32'(fifo_count), 32'd2);

        // Reset while a flit waits for accept discards everything.
        doReset();
        arb_enable = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(16'($urandom) | 16'h1, 6'($urandom) | 6'h1);
        idleInputs();
        arb_enable = 1'b1;
        waitIssue(n, ok);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(rtr_valid), 32'd0);
        checkOutput("mid_rst_data", 32'(rtr_data), 32'd0);
        checkOutput("mid_rst_dest", 32'(rtr_dest_addr), 32'd0);
        checkOutput("mid_rst_empty", 32'(fifo_empty), 32'd1);
        checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("mid_rst_ready", 32'(gpu_in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        p0 = pulse_count;
        repeat (12) @(negedge clk);
        checkOutput("post_rst_quiet", 32'(pulse_count - p0), 32'd0);
        applyStimulus(16'($urandom), 6'($urandom));
        idleInputs();
        drainOne(1'b0, n);
        checkOutput("post_rst_latency", 32'(n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/leaf_gpu_ingress_queue.md
Name: leaf_gpu_ingress_queue

Overview:
Ingress buffer between a GPU port and the leaf router's GPU input (gpu_in_data / gpu_in_valid / gpu_dest_addr). The router has no ready signal, so this block queues GPU flits with their 6-bit destination. It issues them one at a time, using the router's crossbar_busy as an implicit accept. It retries a flit that is not accepted within a timeout, and supplies the full/empty status the router currently ties off.

Parameters:
DWIDTH, 16, flit data width
FIFO_DEPTH, 8, queue entries; power of two, at least 2
TIMEOUT, 15, cycles to wait in WAIT_ACCEPT for crossbar_busy before a retry; at least 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
gpu_in_data  in  DWIDTH  flit from GPU
gpu_in_valid  in  1  GPU flit valid
gpu_in_dest  in  6  destination address from GPU
gpu_in_ready  out  1  queue can accept a flit (= !full)
arb_enable  in  1  shared with router; gates new issues
crossbar_busy  in  1  router busy; rising observation = flit accepted
rtr_data  out  DWIDTH  to router gpu_in_data
rtr_valid  out  1  to router gpu_in_valid; one-cycle pulse per issue
rtr_dest_addr  out  6  to router gpu_dest_addr
fifo_full  out  1  count == FIFO_DEPTH
fifo_empty  out  1  count == 0
fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy
retry_count  out  8  saturating count of timeouts

Behaviour:
- Reset (async, active-high): pointers = 0, count = 0, state = IDLE, wait counter = 0, rtr_valid/rtr_data/rtr_dest_addr = 0, retry_count = 0. fifo_empty = 1, fifo_full = 0, gpu_in_ready = 1 during and after reset. Queue contents are discarded.
- Storage: circular buffer of {dest[5:0], data}. Read and write pointers carry an extra wrap bit. Full = MSBs differ and indices are equal; empty = pointers equal.
- Push: gpu_in_valid && gpu_in_ready at a clock edge writes tail and increments wptr. A valid flit offered while full is not accepted and is not counted; the GPU must hold it.
- gpu_in_ready, fifo_full, fifo_empty and fifo_count are combinational from registered pointers and count, with no bypass.
- Drain FSM:
  - IDLE: if !fifo_empty && arb_enable, go to ISSUE. At that edge, rtr_valid <= 1 and rtr_data/rtr_dest_addr <= head entry. The head is not popped.
  - ISSUE: one cycle. rtr_valid <= 0 at the next edge. Clear the wait counter and go to WAIT_ACCEPT.
  - WAIT_ACCEPT: if crossbar_busy == 1, pop the head (rptr++) and go to WAIT_RELEASE. Otherwise increment the wait counter. When it reaches TIMEOUT, retry_count++ (saturating at 255) and go to IDLE; the same head is reissued.
  - If crossbar_busy and the timeout occur in the same cycle, busy wins: pop, no retry.
  - WAIT_RELEASE: when crossbar_busy == 0, go to IDLE.
- rtr_data and rtr_dest_addr hold their last issued value when rtr_valid = 0.
- Latency: a push into an empty queue at edge N gives rtr_valid high in the cycle after edge N+1, i.e. 2 cycles. Minimum issue-to-issue spacing is 4 cycles.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push into the last free slot in the same cycle as a pop is legal.
- arb_enable low only blocks the IDLE→ISSUE transition. A flit already issued completes its WAIT states.
- Reset asserted mid-operation returns every state to reset values immediately. An in-flight flit is lost and is not retried.
- Wrap-around: pointers wrap modulo 2·FIFO_DEPTH. FIFO order is preserved across wrap.

Decomposition:
- Shared package (noc_pkg): DEST_W = 6, GROUP_ID field position within the destination, and the drain-state enum {IDLE, ISSUE, WAIT_ACCEPT, WAIT_RELEASE}.
- One sub-module: noc_sync_fifo (parameterised by width and depth; push/pop/full/empty/count). The drain FSM and retry logic stay in the top module.

Test Plan:
- Reset then a single push {data = 16'hA5A5, dest = 6'h13}, busy pulsed 1 cycle after rtr_valid → rtr_valid high exactly one cycle, 2 cycles after the push; outputs A5A5/13; fifo_empty returns to 1; retry_count = 0.
- Push 9 flits back-to-back with busy tied low → gpu_in_ready drops after the 8th; fifo_full = 1; fifo_count = 8; the 9th flit is not accepted while ready = 0.
- Queue of 1 flit, crossbar_busy never asserted → reissue every TIMEOUT + 2 cycles with identical data; retry_count increments per timeout; the head is not popped.
- 20 flits pushed and drained with busy responding 1 cycle after each rtr_valid → output order equals input order across pointer wrap; fifo_count ends at 0.
- arb_enable low with 3 flits queued → no rtr_valid. Raise arb_enable → issue within 1 cycle. Drop arb_enable during WAIT_ACCEPT → the current flit still completes on busy.
- Assert reset during WAIT_ACCEPT with 4 flits queued → outputs return immediately to reset values; fifo_empty = 1; no issue after release until a new push.
